// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one read at a time, and holds the
// fetched word in IF/ID with a one-entry skid buffer for decode stalls.
module fetch_stage #(
  parameter int WIDTH = 32,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int OPCODEWIDTH = 4,
  parameter int PC_STEP = 1,
  parameter logic [OPCODEWIDTH-1:0] HALT_OPCODE = 4'hF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        startIO,
  input  logic                        stall,
  input  logic                        branchTaken,
  input  logic [WIDTH-1:0]            branchTarget,
  output logic                        imemReq,
  output logic [WIDTH-1:0]            imemAddr,
  input  logic                        imemGrant,
  input  logic                        imemRvalid,
  input  logic [INSTRUCTIONWIDTH-1:0] imemRdata,
  output logic [INSTRUCTIONWIDTH-1:0] instruction,
  output logic                        instrValid,
  output logic [WIDTH-1:0]            pcOut,
  output logic [WIDTH-1:0]            pcPlus,
  output logic                        halted
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [INSTRUCTIONWIDTH-1:0] instr;
    logic [WIDTH-1:0]            pc;
    logic [WIDTH-1:0]            pcPlus;
  } ifid_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_kill;
  logic             r_halted;
  ifid_t            r_ifid;
  logic             r_valid;
  ifid_t            r_skid;
  logic             r_skidValid;

  logic  w_req;
  logic  w_grant;
  logic  w_branch;
  logic  w_deliver;
  logic  w_free;
  logic  w_isHalt;
  ifid_t w_new;

  // A full skid buffer blocks new requests so the one outstanding
  // response can never find both IF/ID and the skid occupied.
  assign w_req     = (r_state == S_REQ) && !r_skidValid;
  assign w_grant   = w_req && imemGrant;
  assign w_branch  = branchTaken && (r_state != S_HALT);
  assign w_deliver = (r_state == S_WAIT) && imemRvalid
                     && !r_kill && !w_branch;
  assign w_free    = !r_valid || !stall;
  assign w_isHalt  =
    imemRdata[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH] == HALT_OPCODE;
  assign w_new     = '{instr: imemRdata, pc: r_pc, pcPlus: r_pc + STEP};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_kill   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_branch) r_pc <= branchTarget;
          if (startIO) r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_branch) begin
            r_pc <= branchTarget;
            if (w_grant) begin
              r_kill  <= 1'b1;
              r_state <= S_WAIT;
            end
          end else if (w_grant) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_branch) begin
            r_pc <= branchTarget;
            if (imemRvalid) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (imemRvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_pc     <= r_pc + STEP;
              r_state  <= w_isHalt ? S_HALT : S_REQ;
              r_halted <= w_isHalt;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ifid      <= '0;
      r_valid     <= 1'b0;
      r_skid      <= '0;
      r_skidValid <= 1'b0;
    end else if (w_branch) begin
      r_valid     <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (w_free) begin
      if (r_skidValid) begin
        r_ifid      <= r_skid;
        r_valid     <= 1'b1;
        r_skidValid <= 1'b0;
      end else if (w_deliver) begin
        r_ifid  <= w_new;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_deliver) begin
      r_skid      <= w_new;
      r_skidValid <= 1'b1;
    end
  end

  assign imemReq     = w_req;
  assign imemAddr    = r_pc;
  assign instruction = r_ifid.instr;
  assign instrValid  = r_valid;
  assign pcOut       = r_ifid.pc;
  assign pcPlus      = r_ifid.pcPlus;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/branch
// traffic checked against a program-order reference model.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        startIO;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGrant;
  logic        imemRvalid;
  logic [23:0] imemRdata;
  logic [23:0] instruction;
  logic        instrValid;
  logic [31:0] pcOut;
  logic [31:0] pcPlus;
  logic        halted;

  int errors = 0;
  int checks = 0;

  bit          haltEn;
  int          g_prob;
  int          lat_min;
  int          lat_max;
  bit          m_busy;
  int          m_cnt;
  logic [31:0] m_addr;

  fetch_stage dut (
    .clock(clock), .reset(reset), .startIO(startIO), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGrant(imemGrant),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata),
    .instruction(instruction), .instrValid(instrValid),
    .pcOut(pcOut), .pcPlus(pcPlus), .halted(halted)
  );

  always #5 clock = ~clock;

  // Program image: fixed words at 0..3, otherwise a hash whose opcode
  // is never 4'hF so random runs cannot halt.
  function automatic logic [23:0] memf(input logic [31:0] a);
    logic [3:0] op;
    case (a)
      32'd0: return 24'h100001;
      32'd1: return 24'h200002;
      32'd2: return 24'h300003;
      32'd3: return haltEn ? 24'hF00000 : 24'h400004;
      default: begin
        op = 4'(a[5:0] % 6'd15);
        return {op, a[19:0]};
      end
    endcase
  endfunction

  // Memory responder plus one clock; leaves time at posedge+1.
  task automatic step();
    imemGrant  = 1'b0;
    imemRvalid = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        imemRvalid = 1'b1;
        imemRdata  = memf(m_addr);
        m_busy     = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (imemReq && int'($urandom_range(99)) < g_prob) begin
      imemGrant = 1'b1;
      m_addr    = imemAddr;
      m_busy    = 1'b1;
      m_cnt     = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    startIO      = 1'b0;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imemReq, instrValid, halted} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: req=%b valid=%b halted=%b want 0",
               imemReq, instrValid, halted);
    end
    checks++;
    if ({imemAddr, pcOut, pcPlus, instruction} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h pc=%h pcp=%h ins=%h want 0",
               imemAddr, pcOut, pcPlus, instruction);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (imemReq !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: imemReq=%b want 0", imemReq);
      end
    end
  endtask

  task automatic test_sequential();
    logic [23:0] exp_i [3];
    int n;
    exp_i[0] = 24'h100001;
    exp_i[1] = 24'h200002;
    exp_i[2] = 24'h300003;
    n = 0;
    do_reset();
    g_prob = 100; lat_min = 1; lat_max = 1;
    startIO = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (instrValid) begin
        checks++;
        if (pcOut !== 32'(n) || pcPlus !== 32'(n + 1)
            || instruction !== exp_i[n]) begin
          errors++;
          $display("FAIL seq_%0d: pc=%h pcp=%h ins=%h want %h/%h/%h",
                   n, pcOut, pcPlus, instruction, n, n + 1, exp_i[n]);
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL seq_count: got %0d want 3", n);
    end
  endtask

  task automatic test_stall();
    logic [23:0] held_i;
    logic [31:0] held_pc;
    int n;
    do_reset();
    g_prob = 100; lat_min = 1; lat_max = 1;
    startIO = 1'b1;
    for (int c = 0; c < 20 && !instrValid; c++) step();
    checks++;
    if (!instrValid) begin
      errors++;
      $display("FAIL stall_start: instrValid=%b want 1", instrValid);
      return;
    end
    held_i  = instruction;
    held_pc = pcOut;
    stall   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (!instrValid || instruction !== held_i || pcOut !== held_pc) begin
        errors++;
        $display("FAIL stall_hold: v=%b ins=%h pc=%h want 1/%h/%h",
                 instrValid, instruction, pcOut, held_i, held_pc);
      end
    end
    checks++;
    if (imemReq !== 1'b0) begin
      errors++;
      $display("FAIL stall_skid_req: imemReq=%b want 0", imemReq);
    end
    stall = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      if (instrValid) begin
        checks++;
        if (pcOut !== held_pc + 32'(n)
            || instruction !== memf(held_pc + 32'(n))) begin
          errors++;
          $display("FAIL stall_order: pc=%h ins=%h want %h/%h", pcOut,
                   instruction, held_pc + 32'(n), memf(held_pc + 32'(n)));
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d want 4", n);
    end
  endtask

  task automatic test_branch_kill();
    bit seen_req;
    bit seen_ins;
    seen_req = 1'b0;
    seen_ins = 1'b0;
    do_reset();
    g_prob = 100; lat_min = 3; lat_max = 3;
    startIO = 1'b1;
    for (int c = 0; c < 20 && !m_busy; c++) step();
    branchTaken  = 1'b1;
    branchTarget = 32'h40;
    step();
    branchTaken = 1'b0;
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("FAIL br_flush: instrValid=%b want 0", instrValid);
    end
    for (int c = 0; c < 40 && !seen_ins; c++) begin
      if (!seen_req && imemReq) begin
        seen_req = 1'b1;
        checks++;
        if (imemAddr !== 32'h40) begin
          errors++;
          $display("FAIL br_addr: imemAddr=%h want 00000040", imemAddr);
        end
      end
      if (instrValid) begin
        seen_ins = 1'b1;
        checks++;
        if (pcOut !== 32'h40 || pcPlus !== 32'h41
            || instruction !== memf(32'h40)) begin
          errors++;
          $display("FAIL br_first: pc=%h pcp=%h ins=%h want 40/41/%h",
                   pcOut, pcPlus, instruction, memf(32'h40));
        end
      end
      step();
    end
    checks++;
    if (!(seen_req && seen_ins)) begin
      errors++;
      $display("FAIL br_timeout: req=%b ins=%b want 1/1",
               seen_req, seen_ins);
    end
  endtask

  task automatic test_halt();
    int n;
    n = 0;
    do_reset();
    haltEn = 1'b1;
    g_prob = 100; lat_min = 1; lat_max = 1;
    startIO = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      if (instrValid) begin
        checks++;
        if (pcOut !== 32'(n) || instruction !== memf(32'(n))) begin
          errors++;
          $display("FAIL halt_seq: pc=%h ins=%h want %h/%h",
                   pcOut, instruction, n, memf(32'(n)));
        end
        if (n == 3) begin
          checks++;
          if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_flag: halted=%b want 1", halted);
          end
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL halt_count: got %0d want 4", n);
    end
    for (int k = 0; k < 10; k++) begin
      branchTaken  = (k == 4);
      branchTarget = 32'h80;
      step();
      checks++;
      if (imemReq !== 1'b0 || halted !== 1'b1 || instrValid !== 1'b0
          || imemAddr !== 32'd4) begin
        errors++;
        $display("FAIL halt_stay: req=%b h=%b v=%b addr=%h want 0/1/0/4",
                 imemReq, halted, instrValid, imemAddr);
      end
    end
    branchTaken = 1'b0;
    do_reset();
    haltEn = 1'b0;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: halted=%b want 0", halted);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    logic [31:0] ep;
    int n;
    n = 0;
    do_reset();
    g_prob = 100; lat_min = 1; lat_max = 1;
    startIO = 1'b1;
    for (int c = 0; c < 20 && !m_busy; c++) step();
    branchTaken  = 1'b1;
    branchTarget = 32'hFFFF_FFFF;
    step();
    branchTaken = 1'b0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      if (instrValid) begin
        e  = 32'hFFFF_FFFF + 32'(n);
        ep = e + 32'd1;
        checks++;
        if (pcOut !== e || pcPlus !== ep || instruction !== memf(e)) begin
          errors++;
          $display("FAIL wrap_%0d: pc=%h pcp=%h ins=%h want %h/%h/%h",
                   n, pcOut, pcPlus, instruction, e, ep, memf(e));
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 2", n);
    end
  endtask

  task automatic test_reset_mid();
    for (int it = 0; it < 5; it++) begin
      do_reset();
      g_prob  = 50;
      lat_min = 1;
      lat_max = 5;
      startIO = 1'b1;
      for (int c = 0; c < 50 && !m_busy; c++) step();
      for (int c = 0; c < 40 && !(m_busy && m_cnt > 0); c++) step();
      reset = 1'b1;
      step();
      checks++;
      if ({imemReq, imemAddr, instruction, instrValid, pcOut, pcPlus,
           halted} !== '0) begin
        errors++;
        $display("FAIL rst_mid: req=%b addr=%h ins=%h v=%b pc=%h h=%b",
                 imemReq, imemAddr, instruction, instrValid, pcOut, halted);
      end
      reset   = 1'b0;
      startIO = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
          errors++;
          $display("FAIL rst_idle: req=%b v=%b want 0/0",
                   imemReq, instrValid);
        end
      end
      startIO = 1'b1;
      step();
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin
        errors++;
        $display("FAIL rst_restart: req=%b addr=%h want 1/0",
                 imemReq, imemAddr);
      end
    end
  endtask

  // Reference: decode consumes instructions in program order from
  // exp_pc; a branch restarts the order at its target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [23:0] held_i;
    logic [31:0] held_pc;
    bit prev_br;
    bit prev_hold;
    int n;
    exp_pc = '0; held_i = '0; held_pc = '0;
    prev_br = 1'b0; prev_hold = 1'b0; n = 0;
    do_reset();
    haltEn  = 1'b0;
    g_prob  = 60;
    lat_min = 1;
    lat_max = 4;
    startIO = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (prev_br) begin
        checks++;
        if (instrValid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_flush: instrValid=%b want 0", instrValid);
        end
      end
      if (prev_hold) begin
        checks++;
        if (!instrValid || instruction !== held_i || pcOut !== held_pc) begin
          errors++;
          $display("FAIL rnd_hold: v=%b ins=%h pc=%h want 1/%h/%h",
                   instrValid, instruction, pcOut, held_i, held_pc);
        end
      end
      stall        = (int'($urandom_range(99)) < 35);
      branchTaken  = (int'($urandom_range(99)) < 3);
      branchTarget = $urandom();
      if (instrValid && !stall && !branchTaken) begin
        checks++;
        if (pcOut !== exp_pc || pcPlus !== exp_pc + 32'd1
            || instruction !== memf(exp_pc)) begin
          errors++;
          $display("FAIL rnd_seq: pc=%h pcp=%h ins=%h want %h/%h/%h",
                   pcOut, pcPlus, instruction, exp_pc, exp_pc + 32'd1,
                   memf(exp_pc));
        end
        exp_pc = exp_pc + 32'd1;
        n++;
      end
      if (branchTaken) exp_pc = branchTarget;
      prev_br   = branchTaken;
      prev_hold = instrValid && stall && !branchTaken;
      held_i    = instruction;
      held_pc   = pcOut;
      step();
    end
    branchTaken = 1'b0;
    stall       = 1'b0;
    checks++;
    if (n < 30) begin
      errors++;
      $display("FAIL rnd_progress: consumed %0d want >= 30", n);
    end
  endtask

  initial begin
    reset = 1'b1; startIO = 1'b0; stall = 1'b0;
    branchTaken = 1'b0; branchTarget = '0;
    imemGrant = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
    m_busy = 1'b0; m_cnt = 0; m_addr = '0;
    haltEn = 1'b0; g_prob = 100; lat_min = 1; lat_max = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_kill();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
